// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory fetch responder
package imem_pkg;

    typedef enum logic {
        IMEM_IDLE = 1'b0,
        IMEM_BUSY = 1'b1
    } imem_state_e;

    localparam int          CNT_W            = 4;
    localparam logic [31:0] IMEM_NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word-organised instruction store, one write port and one registered read port
module imem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Both ports update on the same edge, so a colliding read returns the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - fixed-latency instruction fetch responder driving the PC stall
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          LATENCY    = 3,
    parameter logic [31:0] NOP_INSTR  = IMEM_NOP_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           instr_o,
    output logic                  valid_o,
    output logic                  err_o,
    output logic                  stall_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i
);

    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      req_addr_q;
    logic             fire;
    logic             req_bad;
    logic             nop_sel_q;
    logic [31:0]      rd_data;

    assign req_bad = (req_addr_q[1:0] != 2'b00) || ((req_addr_q >> (ADDR_WIDTH + 2)) != 32'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!start_i) begin
            state_d = IMEM_IDLE;
        end else begin
            case (state_q)
                IMEM_IDLE: state_d = IMEM_BUSY;
                IMEM_BUSY: if (cnt_q == CNT_W'(1)) state_d = IMEM_IDLE;
                default:   state_d = IMEM_IDLE;
            endcase
        end
    end

    always_comb begin
        fire    = start_i && (state_q == IMEM_BUSY) && (cnt_q == CNT_W'(1));
        stall_o = start_i && !fire;
        instr_o = nop_sel_q ? NOP_INSTR : rd_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            req_addr_q <= '0;
        end else if (start_i && state_q == IMEM_IDLE) begin
            cnt_q      <= CNT_W'(LATENCY);
            req_addr_q <= addr_i;
        end else if (start_i && state_q == IMEM_BUSY && cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Errored fetches and reset select the NOP constant instead of the store output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            valid_o <= fire;
            err_o   <= fire && req_bad;
            if (fire) begin
                nop_sel_q <= req_bad;
            end
        end
    end

    imem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .wr_en   (wr_en_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_en   (fire && !req_bad && !rst_i),
        .rd_addr (req_addr_q[ADDR_WIDTH+1:2]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - scoreboard bench for the fetch responder at LATENCY 3 and 1
module tb_imem_fetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start_v;
    logic [31:0] addr0, addr1;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1, err0, err1, st0, st1;

    always #5 clk = ~clk;

    imem_fetch_responder #(.ADDR_WIDTH(8), .LATENCY(3), .NOP_INSTR(NOP)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .addr_i(addr0),
        .instr_o(instr0), .valid_o(valid0), .err_o(err0), .stall_o(st0),
        .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd)
    );

    imem_fetch_responder #(.ADDR_WIDTH(8), .LATENCY(1), .NOP_INSTR(NOP)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .addr_i(addr1),
        .instr_o(instr1), .valid_o(valid1), .err_o(err1), .stall_o(st1),
        .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: word memory plus, per responder, the fetch in flight and its remaining cycles.
    logic [31:0] mm [256];
    bit          inflight [2];
    int          left [2];
    logic [31:0] lat_addr [2];
    logic [31:0] pc [2];
    bit          collide;
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [31:0] last_instr [2];
    logic [31:0] init4 [4];

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'h400 | $urandom;
            1:       return ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
            default: return $urandom_range(0, 255) * 4;
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit s0, input bit s1, input bit rw,
                         input bit fwe, input logic [7:0] fwa, input logic [31:0] fwd);
        bit          fire [2];
        logic [31:0] a [2];
        logic [32:0] e;
        rst     = r;
        start_v = {s1, s0};
        for (int k = 0; k < 2; k++) begin
            a[k]    = inflight[k] ? $urandom : pc[k];
            fire[k] = inflight[k] && (left[k] == 1) && start_v[k];
        end
        addr0 = a[0];
        addr1 = a[1];
        we = 1'b0;
        if (collide && fire[0] && !r) begin
            we = 1'b1; wa = lat_addr[0][9:2]; wd = 32'hBEEF; collide = 1'b0;
        end else if (fwe) begin
            we = 1'b1; wa = fwa; wd = fwd;
        end else if (rw && $urandom_range(0, 3) == 0) begin
            we = 1'b1; wa = 8'($urandom); wd = $urandom;
        end
        #1;
        check("stall", 0, {31'd0, st0}, {31'd0, s0 & ~fire[0]});
        check("stall", 1, {31'd0, st1}, {31'd0, s1 & ~fire[1]});
        for (int k = 0; k < 2; k++) begin
            if (!r && fire[k]) begin
                e = bad_addr(lat_addr[k]) ? {1'b1, NOP} : {1'b0, mm[lat_addr[k][9:2]]};
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (r || !start_v[k]) begin
                inflight[k] = 1'b0;
            end else if (!inflight[k]) begin
                inflight[k] = 1'b1; left[k] = lat_of(k); lat_addr[k] = a[k];
            end else if (fire[k]) begin
                inflight[k] = 1'b0; pc[k] = pc[k] + 4;
            end else begin
                left[k] = left[k] - 1;
            end
        end
        if (we) mm[wa] = wd;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit s);
        for (int i = 0; i < n; i++) cycle(1'b0, s, s, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    initial begin : monitor
        logic        v, er;
        logic [31:0] ins;
        logic [32:0] ex;
        last_instr[0] = NOP;
        last_instr[1] = NOP;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                v   = (k == 0) ? valid0 : valid1;
                er  = (k == 0) ? err0 : err1;
                ins = (k == 0) ? instr0 : instr1;
                if (rst) begin
                    check("rst_valid", k, {31'd0, v}, 32'd0);
                    check("rst_err", k, {31'd0, er}, 32'd0);
                    check("rst_instr", k, ins, NOP);
                    last_instr[k] = NOP;
                end else if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                    ex = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check("fire_valid", k, {31'd0, v}, 32'd1);
                    check("fire_err", k, {31'd0, er}, {31'd0, ex[32]});
                    check("fire_instr", k, ins, ex[31:0]);
                    last_instr[k] = ex[31:0];
                end else begin
                    check("quiet_valid", k, {31'd0, v}, 32'd0);
                    check("quiet_err", k, {31'd0, er}, 32'd0);
                    check("hold_instr", k, ins, last_instr[k]);
                end
            end
        end
    end

    initial begin : driver
        init4[0] = 32'h11; init4[1] = 32'h22; init4[2] = 32'h33; init4[3] = 32'h44;
        for (int k = 0; k < 2; k++) begin
            inflight[k] = 1'b0; left[k] = 0; lat_addr[k] = '0; pc[k] = '0;
        end
        collide = 1'b0;
        for (int i = 0; i < 256; i++)
            cycle(1'b1, i >= 250, i >= 250, 1'b0, 1'b1, 8'(i), (i < 4) ? init4[i] : $urandom);

        run(17, 1'b1);
        run(2, 1'b0);

        pc[0] = 32'h6; pc[1] = 32'h6;
        run(5, 1'b1);
        run(1, 1'b0);
        pc[0] = 32'h400; pc[1] = 32'h400;
        run(5, 1'b1);
        run(1, 1'b0);

        pc[0] = 32'h0; pc[1] = 32'h0;
        run(2, 1'b1);
        run(2, 1'b0);
        run(5, 1'b1);

        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
        run(5, 1'b1);
        run(1, 1'b0);

        pc[0] = 32'h8; collide = 1'b1;
        run(4, 1'b1);
        run(1, 1'b0);
        pc[0] = 32'h8;
        run(4, 1'b1);
        run(1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 19) == 0) pc[k] = rand_addr();
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) != 0, 1'b1, 1'b0, 8'd0, 32'd0);
        end

        run(3, 1'b0);
        check("drain", 0, 32'(q0.size()), 32'd0);
        check("drain", 1, 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
